// File: rtl/life_pkg.sv
// Shared types and constants for the streaming Life row engine.
package life_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [8:0] CONWAY_BIRTH     = 9'b000001000;
  localparam logic [8:0] CONWAY_SURVIVE   = 9'b000001100;
  localparam logic [8:0] HIGHLIFE_BIRTH   = 9'b001001000;
  localparam logic [8:0] HIGHLIFE_SURVIVE = 9'b000001100;

  function automatic int num_words(input int cols, input int word_w);
    return cols / word_w;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/life_word_cell.sv
// Combinational next generation of one WORD_W-cell slice plus its live count.
// Each slice carries one extra neighbour column on either side (bit 0 = left).
module life_word_cell #(
  parameter int WORD_W = 16,
  parameter int POP_W  = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W+1:0] top_i,
  input  logic [WORD_W+1:0] mid_i,
  input  logic [WORD_W+1:0] bot_i,
  input  logic [8:0]        birth_i,
  input  logic [8:0]        survive_i,
  output logic [WORD_W-1:0] next_o,
  output logic [POP_W-1:0]  pop_o
);

  logic [3:0] n;
  logic       nxt;

  always_comb begin
    next_o = '0;
    pop_o  = '0;
    n      = '0;
    nxt    = 1'b0;
    for (int c = 0; c < WORD_W; c++) begin
      n = 4'(top_i[c]) + 4'(top_i[c+1]) + 4'(top_i[c+2])
        + 4'(mid_i[c])                  + 4'(mid_i[c+2])
        + 4'(bot_i[c]) + 4'(bot_i[c+1]) + 4'(bot_i[c+2]);
      nxt       = mid_i[c+1] ? survive_i[n] : birth_i[n];
      next_o[c] = nxt;
      pop_o     = pop_o + POP_W'(nxt);
    end
  end

endmodule

// File: rtl/life_row_engine.sv
// Streaming Life engine: loads rows into a top/mid/bot window and emits the
// next generation of the mid row word by word with a per-row population count.
module life_row_engine
  import life_pkg::*;
#(
  parameter int         COLS         = 640,
  parameter int         WORD_W       = 16,
  parameter int         ROW_W        = 9,
  parameter bit         WRAP         = 1'b0,
  parameter logic [8:0] BIRTH_MASK   = CONWAY_BIRTH,
  parameter logic [8:0] SURVIVE_MASK = CONWAY_SURVIVE,
  localparam int        NW           = num_words(COLS, WORD_W),
  localparam int        WI_W         = idx_w(NW),
  localparam int        POP_W        = $clog2(COLS + 1),
  localparam int        WPOP_W       = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [WI_W-1:0]   out_word,
  output logic [ROW_W-1:0]  out_row,
  output logic              row_done,
  output logic [POP_W-1:0]  row_pop
);

  localparam logic [WI_W-1:0] LAST_W = WI_W'(NW - 1);

  state_e             state_q, state_d;
  logic [COLS-1:0]    inc_q, inc_d, top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic               vtop_q, vtop_d, vmid_q, vmid_d, vbot_q, vbot_d;
  logic [WI_W-1:0]    wcnt_q, wcnt_d;
  logic               ovld_q, ovld_d;
  logic [WORD_W-1:0]  odat_q, odat_d;
  logic [WI_W-1:0]    oword_q, oword_d;
  logic [WPOP_W-1:0]  opop_q, opop_d;
  logic [ROW_W-1:0]   orow_q, orow_d;
  logic [POP_W-1:0]   acc_q, acc_d, rpop_q, rpop_d;
  logic               done_q, done_d;

  logic               rot, rot_v;
  logic [COLS-1:0]    rot_row;
  logic [POP_W-1:0]   acc_nx;
  logic [WI_W-1:0]    sel_w;
  int                 sbase, wbase;
  logic [COLS+1:0]    top_ext, mid_ext, bot_ext;
  logic [WORD_W+1:0]  top_s, mid_s, bot_s;
  logic [WORD_W-1:0]  cell_next;
  logic [WPOP_W-1:0]  cell_pop;

  // Pads a row with the column -1 / COLS neighbours; invalid rows read as dead.
  function automatic logic [COLS+1:0] extend(input logic [COLS-1:0] row, input logic vld);
    logic [COLS+1:0] e;
    e = {1'b0, row, 1'b0};
    if (WRAP) begin
      e[0]      = row[COLS-1];
      e[COLS+1] = row[0];
    end
    if (!vld) e = '0;
    return e;
  endfunction

  assign top_ext = extend(top_q, vtop_q);
  assign mid_ext = extend(mid_q, vmid_q);
  assign bot_ext = extend(bot_q, vbot_q);
  assign wbase   = int'(wcnt_q) * WORD_W;

  always_comb begin
    sel_w = '0;
    if (ovld_q && oword_q != LAST_W) sel_w = oword_q + 1'b1;
    sbase = int'(sel_w) * WORD_W;
    top_s = top_ext[sbase +: WORD_W+2];
    mid_s = mid_ext[sbase +: WORD_W+2];
    bot_s = bot_ext[sbase +: WORD_W+2];
  end

  life_word_cell #(.WORD_W(WORD_W), .POP_W(WPOP_W)) u_cell (
    .top_i     (top_s),
    .mid_i     (mid_s),
    .bot_i     (bot_s),
    .birth_i   (BIRTH_MASK),
    .survive_i (SURVIVE_MASK),
    .next_o    (cell_next),
    .pop_o     (cell_pop)
  );

  always_comb begin
    state_d = state_q;
    inc_d   = inc_q;
    top_d   = top_q;
    mid_d   = mid_q;
    bot_d   = bot_q;
    vtop_d  = vtop_q;
    vmid_d  = vmid_q;
    vbot_d  = vbot_q;
    wcnt_d  = wcnt_q;
    ovld_d  = ovld_q;
    odat_d  = odat_q;
    oword_d = oword_q;
    opop_d  = opop_q;
    orow_d  = orow_q;
    acc_d   = acc_q;
    rpop_d  = rpop_q;
    done_d  = 1'b0;
    rot     = 1'b0;
    rot_v   = 1'b0;
    rot_row = '0;
    acc_nx  = acc_q + POP_W'(opop_q);

    if (frame_start) begin
      state_d = ST_LOAD;
      inc_d   = '0;
      top_d   = '0;
      mid_d   = '0;
      bot_d   = '0;
      vtop_d  = 1'b0;
      vmid_d  = 1'b0;
      vbot_d  = 1'b0;
      wcnt_d  = '0;
      ovld_d  = 1'b0;
      odat_d  = '0;
      oword_d = '0;
      opop_d  = '0;
      orow_d  = '0;
      acc_d   = '0;
    end else if (state_q == ST_LOAD) begin
      if (in_valid) begin
        inc_d[wbase +: WORD_W] = in_data;
        if (wcnt_q == LAST_W) begin
          rot     = 1'b1;
          rot_v   = 1'b1;
          rot_row = inc_d;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end else if (flush && wcnt_q == '0 && vbot_q) begin
        rot = 1'b1;
      end
    end else begin
      // The first EMIT cycle only fills the output register with word 0.
      if (!ovld_q || out_ready) begin
        if (ovld_q && oword_q == LAST_W) begin
          ovld_d  = 1'b0;
          done_d  = 1'b1;
          rpop_d  = acc_nx;
          acc_d   = '0;
          orow_d  = orow_q + 1'b1;
          state_d = ST_LOAD;
        end else begin
          if (ovld_q) acc_d = acc_nx;
          ovld_d  = 1'b1;
          odat_d  = cell_next;
          oword_d = sel_w;
          opop_d  = cell_pop;
        end
      end
    end

    if (rot) begin
      top_d   = mid_q;
      mid_d   = bot_q;
      bot_d   = rot_row;
      vtop_d  = vmid_q;
      vmid_d  = vbot_q;
      vbot_d  = rot_v;
      wcnt_d  = '0;
      state_d = vbot_q ? ST_EMIT : ST_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      inc_q   <= '0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      vtop_q  <= 1'b0;
      vmid_q  <= 1'b0;
      vbot_q  <= 1'b0;
      wcnt_q  <= '0;
      ovld_q  <= 1'b0;
      odat_q  <= '0;
      oword_q <= '0;
      opop_q  <= '0;
      orow_q  <= '0;
      acc_q   <= '0;
      rpop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      vtop_q  <= vtop_d;
      vmid_q  <= vmid_d;
      vbot_q  <= vbot_d;
      wcnt_q  <= wcnt_d;
      ovld_q  <= ovld_d;
      odat_q  <= odat_d;
      oword_q <= oword_d;
      opop_q  <= opop_d;
      orow_q  <= orow_d;
      acc_q   <= acc_d;
      rpop_q  <= rpop_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = ovld_q;
  assign out_data  = odat_q;
  assign out_word  = oword_q;
  assign out_row   = orow_q;
  assign row_done  = done_q;
  assign row_pop   = rpop_q;

endmodule

// File: tb/tb_life_row_engine.sv
// Bench: three engines (Conway/no-wrap, Conway/wrap, HighLife/no-wrap) share one
// input stream; each emitted row is compared with a whole-grid Life model.
`timescale 1ns/1ps
module tb_life_row_engine;

  localparam int COLS = 32;
  localparam int NW   = 4;
  localparam int RMAX = 8;
  localparam logic [8:0] CB = 9'b000001000;
  localparam logic [8:0] CS = 9'b000001100;
  localparam logic [8:0] HB = 9'b001001000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       irdy [3];
  logic       ovld [3];
  logic       rdone[3];
  logic [7:0] odat [3];
  logic [1:0] owrd [3];
  logic [8:0] orow [3];
  logic [5:0] rpop [3];

  logic [31:0] grid [RMAX];
  logic [31:0] got  [3][RMAX];
  int          got_pop[3][RMAX];
  bit          d_wrap [3] = '{1'b0, 1'b1, 1'b0};
  logic [8:0]  d_birth[3] = '{CB, CB, HB};

  int errors = 0, checks = 0, timeouts = 0, proto_err = 0, done_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (rdone[0] === 1'b1) done_cnt++;

  life_row_engine #(.COLS(32), .WORD_W(8), .ROW_W(9), .WRAP(1'b0),
                    .BIRTH_MASK(CB), .SURVIVE_MASK(CS)) dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data),
    .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odat[0]),
    .out_word(owrd[0]), .out_row(orow[0]), .row_done(rdone[0]), .row_pop(rpop[0]));

  life_row_engine #(.COLS(32), .WORD_W(8), .ROW_W(9), .WRAP(1'b1),
                    .BIRTH_MASK(CB), .SURVIVE_MASK(CS)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data),
    .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odat[1]),
    .out_word(owrd[1]), .out_row(orow[1]), .row_done(rdone[1]), .row_pop(rpop[1]));

  life_row_engine #(.COLS(32), .WORD_W(8), .ROW_W(9), .WRAP(1'b0),
                    .BIRTH_MASK(HB), .SURVIVE_MASK(CS)) dut2 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[2]), .in_data(in_data),
    .out_valid(ovld[2]), .out_ready(out_ready), .out_data(odat[2]),
    .out_word(owrd[2]), .out_row(orow[2]), .row_done(rdone[2]), .row_pop(rpop[2]));

  // Next generation of row k of an R-row frame; rows outside 0..R-1 are dead.
  function automatic logic [31:0] model_row(int k, int R, bit wrap, logic [8:0] bm);
    logic [31:0] res;
    int n, rr, cc;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          rr = k + dr;
          cc = c + dc;
          if (wrap) cc = (cc + COLS) % COLS;
          if (!(dr == 0 && dc == 0) && rr >= 0 && rr < R && cc >= 0 && cc < COLS)
            n += int'(grid[rr][cc]);
        end
      end
      res[c] = grid[k][c] ? CS[n] : bm[n];
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (irdy[0] !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) timeouts++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_row(input int r);
    for (int w = 0; w < NW; w++) send_word(grid[r][w*8 +: 8]);
  endtask

  task automatic collect_row(input int k, input bit stall);
    int w, guard;
    w = 0;
    guard = 0;
    while (w < NW && guard < 500) begin
      out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ovld[0] === 1'b1 && out_ready) begin
        for (int d = 0; d < 3; d++) begin
          got[d][k][w*8 +: 8] = odat[d];
          if (owrd[d] !== 2'(w) || orow[d] !== 9'(k)) proto_err++;
        end
        w++;
      end
      tick();
      guard++;
    end
    if (w < NW) timeouts++;
    for (int d = 0; d < 3; d++) begin
      got_pop[d][k] = int'(rpop[d]);
      if (rdone[d] !== 1'b1) proto_err++;
    end
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input int R, input bit stall);
    pulse_frame_start();
    for (int r = 0; r < R; r++) begin
      send_row(r);
      if (r >= 1) collect_row(r - 1, stall);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    collect_row(R - 1, stall);
  endtask

  task automatic check_frame(input string tag, input int R, input int t0, input int p0);
    logic [31:0] want;
    checks++;
    if (timeouts != t0 || proto_err != p0)
      $display("FAIL %s_protocol: timeouts %0d proto %0d, required 0 0", tag,
               timeouts - t0, proto_err - p0);
    for (int k = 0; k < R; k++) begin
      for (int d = 0; d < 3; d++) begin
        want = model_row(k, R, d_wrap[d], d_birth[d]);
        checks++;
        if (got[d][k] !== want)
          $display("FAIL %s_row%0d_dut%0d: got %h want %h", tag, k, d, got[d][k], want);
        checks++;
        if (got_pop[d][k] != $countones(want))
          $display("FAIL %s_pop%0d_dut%0d: got %0d want %0d", tag, k, d, got_pop[d][k],
                   $countones(want));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    repeat (2) tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (irdy[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready%0d: got %b want 1", d, irdy[d]); end
    end
    checks++;
    if (ovld[0] !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ovld[0]); end
    checks++;
    if (odat[0] !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", odat[0]); end
    checks++;
    if (owrd[0] !== 2'd0) begin errors++; $display("FAIL reset_out_word: got %0d want 0", owrd[0]); end
    checks++;
    if (orow[0] !== 9'd0) begin errors++; $display("FAIL reset_out_row: got %0d want 0", orow[0]); end
    checks++;
    if (rdone[0] !== 1'b0) begin errors++; $display("FAIL reset_row_done: got %b want 0", rdone[0]); end
    checks++;
    if (rpop[0] !== 6'd0) begin errors++; $display("FAIL reset_row_pop: got %0d want 0", rpop[0]); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_blinker();
    int e0, t0, p0;
    e0 = errors; t0 = timeouts; p0 = proto_err;
    for (int r = 0; r < RMAX; r++) grid[r] = '0;
    grid[2] = 32'h0000_0E00;
    run_frame(5, 1'b0);
    check_frame("blinker", 5, t0, p0);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (got[0][k] !== 32'h0000_0400)
        $display("FAIL blinker_const_row%0d: got %h want 00000400", k, got[0][k]);
    end
    errors = e0 + (checks - checks);
    errors = e0;
    recount("blinker", 5);
  endtask

  // Failures inside check_frame and the constant checks are tallied here from
  // a fresh pass so every FAIL line above has exactly one matching increment.
  task automatic recount(input string tag, input int R);
    logic [31:0] want;
    if (timeouts != 0 || proto_err != 0) errors++;
    for (int k = 0; k < R; k++)
      for (int d = 0; d < 3; d++) begin
        want = model_row(k, R, d_wrap[d], d_birth[d]);
        if (got[d][k] !== want) errors++;
        if (got_pop[d][k] != $countones(want)) errors++;
      end
    if (tag == "blinker")
      for (int k = 1; k <= 3; k++) if (got[0][k] !== 32'h0000_0400) errors++;
  endtask

  task automatic test_edge();
    int t0, p0, e0;
    logic [31:0] w0;
    t0 = timeouts; p0 = proto_err; e0 = errors;
    for (int r = 0; r < RMAX; r++) grid[r] = '0;
    for (int r = 1; r <= 3; r++) grid[r] = 32'h0000_0001;
    run_frame(5, 1'b0);
    check_frame("edge", 5, t0, p0);
    errors = e0;
    if (timeouts != t0 || proto_err != p0) errors++;
    for (int k = 0; k < 5; k++)
      for (int d = 0; d < 3; d++) begin
        w0 = model_row(k, 5, d_wrap[d], d_birth[d]);
        if (got[d][k] !== w0) errors++;
        if (got_pop[d][k] != $countones(w0)) errors++;
      end
    checks++;
    if (got[0][2] !== 32'h0000_0003) begin errors++; $display("FAIL edge_nowrap: got %h want 00000003", got[0][2]); end
    checks++;
    if (got[1][2] !== 32'h8000_0003) begin errors++; $display("FAIL edge_wrap: got %h want 80000003", got[1][2]); end
    checks++;
    if (got_pop[1][2] != 3) begin errors++; $display("FAIL edge_wrap_pop: got %0d want 3", got_pop[1][2]); end
  endtask

  task automatic test_highlife();
    int t0, p0, e0;
    logic [31:0] w0;
    t0 = timeouts; p0 = proto_err; e0 = errors;
    for (int r = 0; r < RMAX; r++) grid[r] = '0;
    grid[1] = 32'h0000_0070;
    grid[3] = 32'h0000_0070;
    run_frame(5, 1'b0);
    check_frame("highlife", 5, t0, p0);
    errors = e0;
    if (timeouts != t0 || proto_err != p0) errors++;
    for (int k = 0; k < 5; k++)
      for (int d = 0; d < 3; d++) begin
        w0 = model_row(k, 5, d_wrap[d], d_birth[d]);
        if (got[d][k] !== w0) errors++;
        if (got_pop[d][k] != $countones(w0)) errors++;
      end
    checks++;
    if (got[2][2][5] !== 1'b1) begin errors++; $display("FAIL highlife_birth6: got %b want 1", got[2][2][5]); end
    checks++;
    if (got[0][2][5] !== 1'b0) begin errors++; $display("FAIL conway_no_birth6: got %b want 0", got[0][2][5]); end
  endtask

  task automatic test_latency();
    logic [31:0] want;
    for (int r = 0; r < 2; r++) grid[r] = $urandom;
    want = model_row(0, 2, 1'b0, CB);
    pulse_frame_start();
    send_row(0);
    send_row(1);
    checks++;
    if (ovld[0] !== 1'b0) begin errors++; $display("FAIL latency_t1_valid: got %b want 0", ovld[0]); end
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < NW; i++) begin
      checks++;
      if ({ovld[0], owrd[0]} !== {1'b1, 2'(i)} || odat[0] !== want[i*8 +: 8]) begin
        errors++;
        $display("FAIL latency_word%0d: got v=%b w=%0d d=%h want v=1 w=%0d d=%h", i,
                 ovld[0], owrd[0], odat[0], i, want[i*8 +: 8]);
      end
      tick();
    end
    checks++;
    if ({rdone[0], ovld[0]} !== 2'b10) begin
      errors++;
      $display("FAIL latency_row_done: got done=%b valid=%b want done=1 valid=0", rdone[0], ovld[0]);
    end
    checks++;
    if (int'(rpop[0]) != $countones(want)) begin
      errors++;
      $display("FAIL latency_pop: got %0d want %0d", rpop[0], $countones(want));
    end
    tick();
    checks++;
    if (rdone[0] !== 1'b0) begin errors++; $display("FAIL latency_done_pulse: got %b want 0", rdone[0]); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    logic [7:0]  hold;
    int guard, d0;
    for (int r = 0; r < 2; r++) grid[r] = $urandom;
    want = model_row(0, 2, 1'b1, CB);
    pulse_frame_start();
    send_row(0);
    send_row(1);
    out_ready = 1'b1;
    guard = 0;
    while (!(ovld[1] === 1'b1 && owrd[1] === 2'd2) && guard < 20) begin tick(); guard++; end
    out_ready = 1'b0;
    hold = odat[1];
    d0 = done_cnt;
    checks++;
    if (guard >= 20 || hold !== want[23:16]) begin
      errors++;
      $display("FAIL bp_word2_data: got %h want %h", hold, want[23:16]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (odat[1] !== hold || owrd[1] !== 2'd2 || ovld[1] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got d=%h w=%0d v=%b want d=%h w=2 v=1", i, odat[1], owrd[1], ovld[1], hold);
      end
      checks++;
      if (irdy[1] !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", i, irdy[1]); end
    end
    out_ready = 1'b1;
    guard = 0;
    while (ovld[1] === 1'b1 && guard < 10) begin tick(); guard++; end
    checks++;
    if (rdone[1] !== 1'b1 || int'(rpop[1]) != $countones(want)) begin
      errors++;
      $display("FAIL bp_row_pop: got done=%b pop=%0d want done=1 pop=%0d", rdone[1], rpop[1], $countones(want));
    end
    out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_frame_start_mid();
    int guard, d0;
    bit saw_valid;
    for (int r = 0; r < 3; r++) grid[r] = $urandom;
    pulse_frame_start();
    send_row(0);
    send_row(1);
    collect_row(0, 1'b0);
    send_row(2);
    out_ready = 1'b1;
    guard = 0;
    while (!(ovld[0] === 1'b1 && owrd[0] === 2'd1) && guard < 20) begin tick(); guard++; end
    d0 = done_cnt;
    checks++;
    if (orow[0] !== 9'd1) begin errors++; $display("FAIL fs_pre_row: got %0d want 1", orow[0]); end
    out_ready = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if ({ovld[0], irdy[0], orow[0]} !== {1'b0, 1'b1, 9'd0}) begin
      errors++;
      $display("FAIL fs_clear: got v=%b rdy=%b row=%0d want v=0 rdy=1 row=0", ovld[0], irdy[0], orow[0]);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1) saw_valid = 1'b1;
      tick();
    end
    checks++;
    if (saw_valid) begin errors++; $display("FAIL fs_flush_ignored: got activity=1 want 0"); end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL fs_no_row_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_random();
    int R, t0, p0, d0;
    logic [31:0] want;
    for (int f = 0; f < 4; f++) begin
      R = $urandom_range(1, RMAX);
      for (int r = 0; r < RMAX; r++) grid[r] = $urandom & $urandom;
      t0 = timeouts; p0 = proto_err; d0 = done_cnt;
      run_frame(R, 1'b1);
      tick();
      checks++;
      if (timeouts != t0 || proto_err != p0) begin
        errors++;
        $display("FAIL rand%0d_protocol: timeouts %0d proto %0d, required 0 0", f, timeouts - t0, proto_err - p0);
      end
      checks++;
      if (done_cnt - d0 != R) begin errors++; $display("FAIL rand%0d_done_count: got %0d want %0d", f, done_cnt - d0, R); end
      for (int k = 0; k < R; k++)
        for (int d = 0; d < 3; d++) begin
          want = model_row(k, R, d_wrap[d], d_birth[d]);
          checks++;
          if (got[d][k] !== want || got_pop[d][k] != $countones(want)) begin
            errors++;
            $display("FAIL rand%0d_row%0d_dut%0d: got %h/%0d want %h/%0d", f, k, d,
                     got[d][k], got_pop[d][k], want, $countones(want));
          end
        end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_blinker();
    test_edge();
    test_highlife();
    test_latency();
    test_backpressure();
    test_frame_start_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/life_row_engine.md
Name: life_row_engine

Overview:
- Streaming Conway/Life-like next-generation engine for the VGA Game of Life display path.
- Accepts one cell row at a time as WORD_W-bit words from the DDR read side, and keeps a sliding three-row window (top/mid/bot).
- Emits the next-generation mid row as words for the DDR write side.
- Generalises row width, word width, edge mode and birth/survival rule, and adds per-row population count.

Parameters:
- COLS, 640, cells per row; must be a multiple of WORD_W.
- WORD_W, 16, bits per in/out word; bit b of word w is column w*WORD_W+b.
- ROW_W, 9, width of the output row index.
- WRAP, 0, column edge mode: 1 = toroidal columns, 0 = cells beyond the edges are dead.
- BIRTH_MASK, 9'b000001000, bit n set means a dead cell with n live neighbours is born.
- SURVIVE_MASK, 9'b000001100, bit n set means a live cell with n live neighbours survives.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- frame_start  in  1  synchronous frame restart pulse.
- flush  in  1  shift in a dead row without reading (end of frame).
- in_valid  in  1  input word valid.
- in_ready  out  1  engine accepts an input word.
- in_data  in  WORD_W  input cell word.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  WORD_W  next-generation cell word.
- out_word  out  clog2(COLS/WORD_W)  index of out_data within the row.
- out_row  out  ROW_W  index of the row being emitted; 0 = first row of the frame.
- row_done  out  1  one-cycle pulse after the last word of a row is accepted.
- row_pop  out  clog2(COLS+1)  live-cell count of the emitted row; valid while row_done is high.

Behaviour:
- Reset: state LOAD, all row buffers 0, valid flags vtop/vmid/vbot 0, word counter 0, out_row 0. Outputs: in_ready 1, out_valid 0, out_data 0, out_word 0, row_done 0, row_pop 0.
- Storage: staging row INC plus TOP, MID, BOT (COLS bits each), each with a valid flag.

State LOAD (in_ready=1):
- Each in_valid&in_ready handshake writes in_data into INC word wcnt, then wcnt++.
- On the handshake with wcnt=NW-1 (NW=COLS/WORD_W): next edge performs ROTATE.
  - TOP<=MID, MID<=BOT, BOT<=INC; vtop<=vmid, vmid<=vbot, vbot<=1; wcnt<=0.
- flush while wcnt=0 and vbot=1: next edge performs ROTATE with an all-zero row and vbot<=0.
- flush while wcnt!=0 or vbot=0: ignored.
- in_valid and flush together: in_valid wins.
- After ROTATE: enter EMIT if the new vmid=1; otherwise stay in LOAD.

State EMIT (in_ready=0):
- For word w, each cell c computes n = live neighbours among the 8 around MID[c], using TOP/MID/BOT.
  - Invalid rows count as dead.
  - Column -1 and column COLS use WRAP mode.
- next = MID[c] ? SURVIVE_MASK[n] : BIRTH_MASK[n]. n is a 4-bit unsigned value.
- Output register: out_data/out_word are loaded on the EMIT entry edge plus 1. out_valid rises on that edge, so the first out_valid comes 2 cycles after the last input handshake.
- out_data/out_word/out_row are held stable while out_valid&!out_ready.
- After each out handshake the next word is presented on the following edge, one word per cycle under full throughput.
- A popcount accumulator adds each accepted word.
- After the handshake on word NW-1:
  - out_valid<=0, row_done<=1 for one cycle, row_pop = final sum.
  - Accumulator cleared, out_row++ (wraps at 2^ROW_W), return to LOAD.

frame_start:
- Highest priority, in any state, including mid-row and with out_valid stalled.
- Next edge: buffers and valid flags cleared, wcnt=0, out_row=0, out_valid=0, accumulator 0, state LOAD.
- Does not assert row_done.

Frame sequence:
- frame_start, then rows 0..R-1, then one flush.
- Row k is emitted after row k+1 (or the flush) is loaded. Row 0 sees a dead TOP.

Decomposition:
- Package life_pkg: state enum (LOAD, EMIT), default birth/survive masks (CONWAY, HIGHLIFE B36/S23), and a function computing NW and index widths.
- Sub-module life_word_cell: combinational next-state of one WORD_W slice.
  - Inputs: three (WORD_W+2)-bit neighbourhood slices plus the masks.
  - Outputs: next word and its popcount.
- The control FSM, buffers and handshakes live in life_row_engine.

Test Plan:
- Blinker, COLS=32, WORD_W=8, WRAP=0: frame_start, then rows 0..4 with row2=0x0000_0E00 and the rest 0, then flush.
  - Expect row1 out 0x0000_0400, row2 0x0000_0400, row3 0x0000_0400.
  - Expect row_pop 1,1,1 on those rows and 0 on the others.
- Edge mode, COLS=32, WORD_W=8: vertical triple at column 0 in rows 1..3.
  - WRAP=0: row2 emits 0x0000_0003.
  - WRAP=1: row2 emits 0x8000_0003, row_pop 3.
- Backpressure: hold out_ready=0 for 5 cycles on word 2.
  - out_data/out_word stay constant, in_ready stays 0.
  - Releasing out_ready completes the row; row_done pulses exactly once.
- Latency: the last input handshake at cycle T gives out_valid=1 at T+2 with out_word=0. With out_ready=1, 4 words complete at T+2..T+5 and row_done pulses at T+6.
- frame_start mid-EMIT on word 1: the next cycle has out_valid=0, in_ready=1 and out_row=0. No row_done. A subsequent flush with no rows loaded is ignored.
- HighLife masks (BIRTH=9'b001001000): a dead cell with 6 live neighbours becomes 1; under Conway masks the same cell stays 0.
